// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default sizes for the core's program-flow control logic.
package cpu_ctrl_pkg;

   localparam int unsigned DEF_PC_W     = 12;
   localparam int unsigned DEF_REG_AW   = 5;
   localparam int unsigned DEF_RESET_PC = 0;

   // Sequencer run state; STEP is reachable only in single-step builds
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      STEP = 2'd2
   } seq_state_t;

endpackage : cpu_ctrl_pkg

// File: rtl/fwd_unit.sv
// WB->EX operand forwarding comparators; x0 is never forwarded and bubbles never forward.
module fwd_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = DEF_REG_AW
) (
   input  logic [REG_AW-1:0] rs1_ex,
   input  logic [REG_AW-1:0] rs2_ex,
   input  logic [REG_AW-1:0] rd_wb,
   input  logic              regwrite_wb,
   input  logic              valid_ex,
   output logic              fwd_a,
   output logic              fwd_b
);

   logic wb_live;

   // Compare the WB destination against both EX sources
   always_comb begin
      wb_live = regwrite_wb & (rd_wb != '0) & valid_ex;
      fwd_a   = wb_live & (rd_wb == rs1_ex);
      fwd_b   = wb_live & (rd_wb == rs2_ex);
   end

endmodule : fwd_unit

// File: rtl/pc_sequencer.sv
// Fetch PC, wrong-path squash, RUN/HALT control, forwarding selects and retired count.
// Optional feature macro: SINGLE_STEP_EN adds the STEP state driven by the step input.
module pc_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned PC_W     = DEF_PC_W,
   parameter int unsigned RESET_PC = DEF_RESET_PC,
   parameter int unsigned REG_AW   = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_ex,
   input  logic [PC_W-1:0]   target_ex,
   input  logic              halt_req_ex,
   input  logic              resume,
   input  logic              step,
   input  logic [REG_AW-1:0] rs1_ex,
   input  logic [REG_AW-1:0] rs2_ex,
   input  logic [REG_AW-1:0] rd_wb,
   input  logic              regwrite_wb,
   output logic [PC_W-1:0]   pc_f,
   output logic              fetch_en,
   output logic              valid_ex,
   output logic              fwd_a,
   output logic              fwd_b,
   output logic              halted,
   output logic [31:0]       instret
);

   localparam int unsigned CNT_W = 32;

   seq_state_t       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             redir, hlt;

`ifndef SINGLE_STEP_EN
   logic unused_step;
   assign unused_step = step;
`endif

   // State, PC, EX-valid and retired-count registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RUN;
         pc_q      <= PC_W'(RESET_PC);
         valid_q   <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         valid_q   <= valid_d;
         instret_q <= instret_d;
      end
   end

   // Next-state, next-PC and fetch control; EX requests from bubbles are ignored
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      valid_d   = 1'b0;
      fetch_en  = 1'b0;
      halted    = 1'b0;
      redir     = redirect_ex & valid_q;
      hlt       = halt_req_ex & valid_q;
      instret_d = instret_q + (valid_q ? CNT_W'(1) : CNT_W'(0));

      case (state_q)
         RUN: begin
            fetch_en = 1'b1;
            if (hlt) state_d = HALT;
         end
         HALT: begin
            halted = 1'b1;
            if (resume) state_d = RUN;
`ifdef SINGLE_STEP_EN
            else if (step) state_d = STEP;
`endif
         end
`ifdef SINGLE_STEP_EN
         STEP: begin
            fetch_en = 1'b1;
            state_d  = HALT;
         end
`endif
         default: state_d = RUN;
      endcase

      // Redirect wins over halt so a resume fetches the branch target
      valid_d = fetch_en & ~redir & ~hlt;
      if (redir)         pc_d = target_ex;
      else if (hlt)      pc_d = pc_q;
      else if (fetch_en) pc_d = pc_q + PC_W'(1);
   end

   assign pc_f     = pc_q;
   assign valid_ex = valid_q;
   assign instret  = instret_q;

   // Forwarding selects
   fwd_unit #(
      .REG_AW (REG_AW)
   ) u_fwd (
      .rs1_ex      (rs1_ex),
      .rs2_ex      (rs2_ex),
      .rd_wb       (rd_wb),
      .regwrite_wb (regwrite_wb),
      .valid_ex    (valid_q),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b)
   );

endmodule : pc_sequencer
